// File: rtl/dma_arbiter.sv
// dma_arbiter: shares one DMA controller port between NUM_DEV peripherals.
// A device is granted for a whole transfer (request to end-of-operation).
// Its request, direction, address, word count, data and ack go to the
// controller. The controller ack and end flag return to that device only.
//
// Optional feature macro: DMA_ARB_FIXED_PRIO_EN
//   defined   -> lowest-index requester wins in IDLE
//   undefined -> round-robin starting after the last granted device
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   dev_rqst/rd_wr/ack     per-device request, direction, handshake ack
//   dev_start_address,
//   dev_num_words, dev_out per-device 16-bit fields, device i at [16i+15:16i]
//   dev_dma_ack/end_flag   controller ack / end flag, granted device only
//   dma_*                  muxed signals to/from the DMA controller
//   grant                  one-hot current grant
//   busy                   high while a transfer owns the controller
module dma_arbiter #(
  parameter int unsigned NUM_DEV    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DEV-1:0]    dev_rqst,
  input  logic [NUM_DEV-1:0]    dev_rd_wr,
  input  logic [16*NUM_DEV-1:0] dev_start_address,
  input  logic [16*NUM_DEV-1:0] dev_num_words,
  input  logic [16*NUM_DEV-1:0] dev_out,
  input  logic [NUM_DEV-1:0]    dev_ack,
  output logic [NUM_DEV-1:0]    dev_dma_ack,
  output logic [NUM_DEV-1:0]    dev_dma_end_flag,
  output logic                  dma_rqst,
  output logic                  dma_rd_wr,
  output logic [15:0]           dma_start_address,
  output logic [15:0]           dma_num_words,
  output logic [15:0]           dma_dev_out,
  output logic                  dma_dev_ack,
  input  logic                  dma_ack,
  input  logic                  dma_end_flag,
  output logic [NUM_DEV-1:0]    grant,
  output logic                  busy
);

  localparam int unsigned IW = (NUM_DEV > 2) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, GRANTED, DRAIN, GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_DEV-1:0] grant_nxt;
  logic [IW-1:0]      last, last_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      win;
  logic [IW-1:0]      cand;
  logic               win_vld;
  logic               g_rqst;

  // Index of the currently granted device (0 when nothing is granted)
  always_comb begin
    gidx = '0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      if (grant[IW'(i)]) gidx = IW'(i);
    end
  end

  assign g_rqst = |(dev_rqst & grant);

  // Winner selection; loops run backwards so the preferred candidate is written last
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
`ifdef DMA_ARB_FIXED_PRIO_EN
    for (int i = int'(NUM_DEV) - 1; i >= 0; i--) begin
      cand = IW'(i);
      if (dev_rqst[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
`else
    for (int k = int'(NUM_DEV); k >= 1; k--) begin
      cand = IW'((int'(last) + k) % int'(NUM_DEV));
      if (dev_rqst[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= GAP;
      grant <= '0;
      last  <= IW'(NUM_DEV - 1);
      cnt   <= CW'(GAP_CYCLES);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          grant_nxt = {{(NUM_DEV-1){1'b0}}, 1'b1} << win;
          last_nxt  = win;
          state_nxt = GRANTED;
        end
      end
      GRANTED: begin
        // End flag takes precedence over a simultaneous request drop
        if (dma_end_flag) begin
          state_nxt = DRAIN;
        end else if (!g_rqst) begin
          state_nxt = GAP;
          grant_nxt = '0;
          cnt_nxt   = CW'(GAP_CYCLES);
        end
      end
      DRAIN: begin
        if (!g_rqst && !dma_end_flag) begin
          state_nxt = GAP;
          grant_nxt = '0;
          cnt_nxt   = CW'(GAP_CYCLES);
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = GAP;
    endcase
  end

  // Routing mux; everything is zero while no device holds the grant
  always_comb begin
    dma_rqst          = 1'b0;
    dma_rd_wr         = 1'b0;
    dma_dev_ack       = 1'b0;
    dma_start_address = '0;
    dma_num_words     = '0;
    dma_dev_out       = '0;
    if (grant != '0) begin
      dma_rqst          = (state == GRANTED) && dev_rqst[gidx];
      dma_rd_wr         = dev_rd_wr[gidx];
      dma_dev_ack       = dev_ack[gidx];
      dma_start_address = DW'(dev_start_address >> (DW * gidx));
      dma_num_words     = DW'(dev_num_words >> (DW * gidx));
      dma_dev_out       = DW'(dev_out >> (DW * gidx));
    end
  end

  assign dev_dma_ack      = grant & {NUM_DEV{dma_ack}};
  assign dev_dma_end_flag = grant & {NUM_DEV{dma_end_flag}};
  assign busy             = (state == GRANTED) || (state == DRAIN);

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter (NUM_DEV = 4, GAP_CYCLES = 2).
module tb_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dev_rqst;
  logic [3:0]  dev_rd_wr;
  logic [63:0] dev_start_address;
  logic [63:0] dev_num_words;
  logic [63:0] dev_out;
  logic [3:0]  dev_ack;
  logic [3:0]  dev_dma_ack;
  logic [3:0]  dev_dma_end_flag;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic [15:0] dma_dev_out;
  logic        dma_dev_ack;
  logic        dma_ack;
  logic        dma_end_flag;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dma_arbiter #(.NUM_DEV(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr),
    .dev_start_address(dev_start_address), .dev_num_words(dev_num_words),
    .dev_out(dev_out), .dev_ack(dev_ack),
    .dev_dma_ack(dev_dma_ack), .dev_dma_end_flag(dev_dma_end_flag),
    .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
    .dma_dev_out(dma_dev_out), .dma_dev_ack(dma_dev_ack),
    .dma_ack(dma_ack), .dma_end_flag(dma_end_flag),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Waits for a grant; from a fresh GAP entry 4 grant-free observations precede it
  task automatic wait_grant(input logic [3:0] exp, input bit chk_gap);
    int zc = 0;
    int n = 0;
    while (grant == 4'b0 && n < 30) begin
      zc++;
      step();
      n++;
    end
    if (chk_gap) chk("gap_len", zc, 4);
    chk("grant", grant, exp);
  endtask

  // One full transfer: grant, routing checks, end flag, release
  task automatic serve(input logic [3:0] exp, input bit rerq);
    int i;
    wait_grant(exp, 1'b1);
    i = oh2i(exp);
    chk("addr", dma_start_address, 32'h0200 + 32'h1000 * i);
    chk("nwords", dma_num_words, 3 + i);
    chk("dout", dma_dev_out, 32'hA000 + i);
    chk("rd_wr", dma_rd_wr, (i % 2 == 0) ? 1 : 0);
    chk("dma_rqst", dma_rqst, 1);
    chk("busy", busy, 1);
    dma_ack = 1'b1;
    dev_ack = exp;
    #1;
    chk("ack_route", dev_dma_ack, exp);
    chk("dev_ack_route", dma_dev_ack, 1);
    dma_ack = 1'b0;
    dev_ack = 4'b0;
    dma_end_flag = 1'b1;
    #1;
    chk("end_route", dev_dma_end_flag, exp);
    step();
    dma_end_flag = 1'b0;
    dev_rqst = dev_rqst & ~exp;
    step();
    chk("release", grant, 0);
    if (rerq) dev_rqst = dev_rqst | exp;
  endtask

  initial begin
    logic [3:0] exp_g;
    reset        = 1'b1;
    dev_rqst     = 4'b0;
    dev_rd_wr    = 4'b0101;
    dev_ack      = 4'b0;
    dma_ack      = 1'b1;
    dma_end_flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dev_start_address[16*i +: 16] = 16'h0200 + 16'(16'h1000 * i);
      dev_num_words[16*i +: 16]     = 16'(3 + i);
      dev_out[16*i +: 16]           = 16'hA000 + 16'(i);
    end

    // Reset: nothing granted or routed even with controller signals high
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", dev_dma_ack, 0);
    chk("rst_end", dev_dma_end_flag, 0);
    dma_ack      = 1'b0;
    dma_end_flag = 1'b0;

    // Single requester, device 0 wins first
    dev_rqst = 4'b0001;
    reset    = 1'b0;
    serve(4'b0001, 1'b0);

    // Two simultaneous requests: round-robin from device 1
    dev_rqst = 4'b1010;
    serve(4'b0010, 1'b0);
    serve(4'b1000, 1'b0);

    // All four continuously requesting
    dev_rqst = 4'b1111;
    serve(4'b0001, 1'b1);
    serve(4'b0010, 1'b1);
    serve(4'b0100, 1'b1);
    serve(4'b1000, 1'b1);
    serve(4'b0001, 1'b0);
    serve(4'b0010, 1'b0);

    // Abort: device 2 drops its request without an end flag
    wait_grant(4'b0100, 1'b1);
    dev_rqst = 4'b1000;
    #1;
    chk("abort_rqst", dma_rqst, 0);
    step();
    chk("abort_grant", grant, 0);
    chk("abort_busy", busy, 0);
    dev_rqst = 4'b1100;
    serve(4'b1000, 1'b0);
    serve(4'b0100, 1'b0);

    // Drain: device 1 holds its request two cycles after the end flag
    dev_rqst = 4'b0010;
    wait_grant(4'b0010, 1'b1);
    dma_end_flag = 1'b1;
    step();
    chk("drain_end", dev_dma_end_flag, 4'b0010);
    chk("drain_rqst", dma_rqst, 0);
    chk("drain_busy", busy, 1);
    step();
    dma_end_flag = 1'b0;
    chk("drain_hold1", grant, 4'b0010);
    step();
    chk("drain_hold2", grant, 4'b0010);
    dev_rqst = 4'b0000;
    step();
    chk("drain_release", grant, 0);

    // Device 0 re-requests every release while device 3 requests continuously
    dev_rqst = 4'b1001;
    for (int k = 0; k < 4; k++) begin
`ifdef DMA_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = (k % 2 == 0) ? 4'b1000 : 4'b0001;
`endif
      serve(exp_g, 1'b1);
    end

    // Reset mid-transfer clears everything at once, restart from device 0
`ifdef DMA_ARB_FIXED_PRIO_EN
    wait_grant(4'b0001, 1'b1);
`else
    wait_grant(4'b1000, 1'b1);
`endif
    dma_ack = 1'b1;
    reset   = 1'b1;
    #1;
    chk("amid_grant", grant, 0);
    chk("amid_rqst", dma_rqst, 0);
    chk("amid_ack", dev_dma_ack, 0);
    chk("amid_addr", dma_start_address, 0);
    dma_ack = 1'b0;
    step();
    reset = 1'b0;
    wait_grant(4'b0001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
Shares the single DMA controller port between NUM_DEV DMA-capable peripherals of the simple DMA device type. It grants the controller to one requester for a whole transfer, from request to end-of-operation, and routes that requester's request, address, length, data and acknowledge to the controller. Controller acknowledge and end flag go back to the granted device only. Sits between the peripheral DMA devices and the DMA controller; it has no CPU-visible registers.

Parameters:
NUM_DEV, 4, number of requesting devices (2..8); index width IW = clog2(NUM_DEV), minimum 1.
GAP_CYCLES, 2, idle cycles forced between releasing one grant and issuing the next (0..15).

Ports:
clk  in  1  main system clock
reset  in  1  asynchronous active-high reset
dev_rqst  in  NUM_DEV  per-device DMA request
dev_rd_wr  in  NUM_DEV  per-device direction; 1 = read, 0 = write
dev_start_address  in  16*NUM_DEV  per-device start address; device i uses bits [16i+15:16i]
dev_num_words  in  16*NUM_DEV  per-device word count, packed as above
dev_out  in  16*NUM_DEV  per-device write data, packed as above
dev_ack  in  NUM_DEV  per-device handshake acknowledge
dev_dma_ack  out  NUM_DEV  controller acknowledge, routed to the granted device only
dev_dma_end_flag  out  NUM_DEV  controller end flag, routed to the granted device only
dma_rqst  out  1  request to the controller
dma_rd_wr  out  1  direction to the controller
dma_start_address  out  16  start address to the controller
dma_num_words  out  16  word count to the controller
dma_dev_out  out  16  write data to the controller
dma_dev_ack  out  1  device acknowledge to the controller
dma_ack  in  1  controller acknowledge
dma_end_flag  in  1  controller end-of-operation
grant  out  NUM_DEV  one-hot current grant (status/debug)
busy  out  1  high in GRANTED and DRAIN

Behaviour:
- Registers: state, grant (one-hot), last index (IW bits), gap counter (4 bits).
- Reset values: state = GAP, gap counter = GAP_CYCLES, grant = 0, last index = NUM_DEV-1, so device 0 wins first. All outputs are 0 during and after reset until the first grant.
- State IDLE: evaluate dev_rqst.
  - If any bit is set, pick the winner round-robin, searching from (last+1) mod NUM_DEV upward with wrap.
  - Register grant, set last = winner, and go to GRANTED. Grant is visible the cycle after the request is sampled (1-cycle latency).
- State GRANTED: a combinational mux by grant drives dma_rqst = dev_rqst[g] and the other dma_* outputs from device g.
  - dev_dma_ack[g] = dma_ack; dev_dma_end_flag[g] = dma_end_flag; all other bits of both are 0.
  - Outputs with grant = 0: dma_rqst, dma_rd_wr, dma_dev_ack = 0, data buses = 0.
  - dma_end_flag = 1 -> DRAIN.
  - dev_rqst[g] falls without an end flag (abort) -> GAP with gap counter = GAP_CYCLES, grant cleared.
  - End flag and request drop in the same cycle -> DRAIN (the end flag wins).
- State DRAIN: grant is held and the end-flag routing is kept so the device can latch END_OP.
  - dma_rqst is forced to 0.
  - Leave for GAP when dev_rqst[g] = 0 and dma_end_flag = 0; clear grant and load the gap counter.
- State GAP: decrement the counter each cycle. At 0 -> IDLE. With GAP_CYCLES = 0, go to IDLE on the next cycle.
- Requests arriving in GRANTED, DRAIN or GAP are not lost. They are level-sensitive and sampled in IDLE.
- Multiple simultaneous requests: exactly one grant. The others wait and are served in round-robin order with no starvation.
- Grant is never reissued to the same device while another device is requesting, unless it is the only requester.
- Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronous). Arbitration restarts from device 0.

Optional Feature:
DMA_ARB_FIXED_PRIO_EN
- Defined: the IDLE winner is the lowest-index requesting device (device 0 highest priority). The last index is not used for selection.
- Undefined: round-robin as above.
- All other state behaviour is identical.

Test Plan:
- Reset, then dev_rqst = 4'b0001 with address 0x0200, 3 words, read -> grant = 0001 one cycle later; dma_start_address = 0x0200, dma_num_words = 3; dma_ack reaches dev_dma_ack[0] only.
- dev_rqst = 4'b1010 simultaneously, each holding until its end flag -> device 1 served first, then device 3. Between the two transfers grant = 0 for at least GAP_CYCLES + 1 = 3 cycles.
- All four devices request continuously, each releasing after its end flag -> grant order 0,1,2,3,0; each grant is one-hot.
- Device 2 drops dev_rqst mid-transfer with no end flag -> dma_rqst = 0 next cycle, grant = 0, state GAP then IDLE; device 2 is not regranted before the other pending requesters.
- dma_end_flag pulse while device 1 is granted; device 1 holds dev_rqst 2 more cycles -> dev_dma_end_flag = 0010, dma_rqst = 0 in DRAIN, grant released the cycle after dev_rqst[1] falls.
- With DMA_ARB_FIXED_PRIO_EN, device 0 rerequests every time it is released while device 3 requests continuously -> device 0 is always granted and device 3 is never granted.
